timer_csr: RTL and testbench
============================

# timer_csr

Native-bus register responder that owns the 64-bit timer core. It turns CPU register accesses into the timer's control inputs (enable, wrap value, sample strobe). It also reads the timer's sampled count back as a coherent 64-bit snapshot, split into two 32-bit reads. It sits between the system interconnect and the timer core.

## Interface
- DATA_W, 32: bus data width; timer count is 2*DATA_W.
- ADDR_W, 3: word address width; 8 word slots.

- clk  in  1  system clock.
- rst  in  1  reset: one clock, synchronous, active-high.
- valid  in  1  bus request; held high until `ready` is returned.
- address  in  ADDR_W  word address.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte write strobes; all-zero means read.
- rdata  out  DATA_W  read data; valid only while `ready`=1.
- ready  out  1  single-cycle completion pulse.
- timer_en  out  1  to timer TIMER_EN.
- wrap_h  out  DATA_W  to timer WRAP_H.
- wrap_l  out  DATA_W  to timer WRAP_L.
- timer_s  out  1  to timer TIMER_S; one-cycle pulse.
- timer_count  in  2*DATA_W  from timer TIMER_COUNT.

## Operation
- Register map (word address):
  - 0 CTRL: RW; bit0 = enable, drives `timer_en`.
  - 1 SAMPLE: WO; any write starts a sample sequence. Reads return 0.
  - 2 WRAP_L: RW.
  - 3 WRAP_H: RW.
  - 4 COUNT_L: RO; snapshot[31:0].
  - 5 COUNT_H: RO; snapshot[63:32].
  - 6 STATUS: RO; bit0 = busy, bit1 = snap_valid.
  - 7: reserved; reads 0, writes ignored.
- RW registers honour `wstrb` per byte. Writes to RO addresses are ignored.
- Sample FSM:
  - IDLE -> PULSE on an accepted SAMPLE write.
  - PULSE (`timer_s`=1) -> WAIT.
  - WAIT -> CAPTURE.
  - CAPTURE: snapshot <= `timer_count`, snap_valid <= 1; -> IDLE.
  - busy = (state != IDLE).
- A SAMPLE write accepted while busy completes normally on the bus but is ignored: no restart and no extra pulse.
- An accepted SAMPLE write clears snap_valid. It stays 0 until CAPTURE.
- Snapshot registers change only in CAPTURE. COUNT_L and COUNT_H read back-to-back are therefore coherent.
- Writing CTRL.enable=0 during a sequence does not abort it; the capture still occurs.
- WRAP_L/WRAP_H reach the timer directly from the registers. Software writes WRAP before setting enable.

## Timing
- Every output resets to 0: `rdata`, `ready`, `timer_en`, `wrap_h`, `wrap_l`, `timer_s`. Snapshot, snap_valid and FSM (IDLE) also reset.
- Bus:
  - `valid` sampled in cycle N -> `ready`=1 and `rdata` valid in cycle N+1.
  - `ready` is low in N+2 even if `valid` is still high.
  - A new request is accepted in N+2 at the earliest; at most one access per two cycles.
- Write effects (register update, FSM start) occur at the edge ending cycle N. Effects are visible in N+1.
- Sample sequence for a SAMPLE write accepted in cycle N:
  - `timer_s`=1 in cycle N+1 only.
  - The timer updates TIMER_COUNT at the end of N+1.
  - Capture at the edge ending N+3.
  - busy=1 in N+1..N+3. snap_valid=1 and COUNT readable from N+4.
- STATUS read in cycle N+1 returns busy=1.
- `rst` high mid-sequence: FSM -> IDLE and `timer_s`=0 in the next cycle. An in-flight `ready` is dropped.
- A write to CTRL and a capture in the same cycle are independent; both take effect.

## Test plan
- Reset: hold `rst` 7 cycles -> all outputs 0. Reads of every address return 0 except STATUS=0.
- Config/readback: write WRAP_L=150, WRAP_H=0, CTRL=1 -> `wrap_l`=150, `timer_en`=1 one cycle after each `ready`. Readbacks match. Write CTRL with wstrb=0b0000 -> treated as read, no change.
- Sample: after 100 enabled cycles, write SAMPLE at cycle N.
  - `timer_s` high exactly in N+1.
  - STATUS=1 at N+1, STATUS=2 from N+4.
  - COUNT_L equals the model count at sample time; COUNT_H=0.
- Re-trigger while busy: second SAMPLE write at N+2 -> exactly one `timer_s` pulse. Snapshot identical to the single-sample case.
- Coherence: force `timer_count` to 0x0000_0000_FFFF_FFFF, sample, then change the input to 0x0000_0001_0000_0000 -> COUNT_L=0xFFFF_FFFF and COUNT_H=0.
- Reset mid-sample: assert `rst` at N+2 -> `timer_s`=0, busy=0, snap_valid=0, snapshot=0. Next bus access completes normally.

Source files
------------

// File: rtl/timer_csr.sv
// Register responder for the 64-bit timer: enable/wrap config, sample strobe, coherent COUNT snapshot.
// Latency 1: ready pulses the cycle after valid; a held valid completes at most every other cycle.
module timer_csr #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  output logic                  timer_en,
  output logic [DATA_W-1:0]     wrap_h,
  output logic [DATA_W-1:0]     wrap_l,
  output logic                  timer_s,
  input  logic [2*DATA_W-1:0]   timer_count
);

  localparam int STRB_W = DATA_W / 8;

  localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_SAMPLE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_WRAP_L  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_WRAP_H  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_COUNT_L = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_COUNT_H = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(6);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PULSE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  logic                accept;
  logic                is_write;
  logic                sample_wr;
  logic                busy;
  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [DATA_W-1:0]   wmask;
  logic [DATA_W-1:0]   rd_mux;
  logic [2*DATA_W-1:0] snap;
  logic                snap_valid;

  // While ready is high the current request is completing, so it is never accepted twice.
  assign accept    = valid && !ready;
  assign is_write  = accept && (wstrb != '0);
  assign sample_wr = is_write && (address == A_SAMPLE);
  assign busy      = (state != S_IDLE);
  assign timer_s   = (state == S_PULSE);

  always_comb begin
    wmask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      wmask[b*8 +: 8] = {8{wstrb[b]}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_en <= 1'b0;
      wrap_l   <= '0;
      wrap_h   <= '0;
    end else if (is_write) begin
      case (address)
        A_CTRL:   if (wstrb[0]) timer_en <= wdata[0];
        A_WRAP_L: wrap_l <= (wrap_l & ~wmask) | (wdata & wmask);
        A_WRAP_H: wrap_h <= (wrap_h & ~wmask) | (wdata & wmask);
        default:  ;
      endcase
    end
  end

  // The timer latches TIMER_COUNT at the end of the pulse cycle; WAIT lets that settle before capture.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (sample_wr) state_nxt = S_PULSE;
      S_PULSE: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_CAPTURE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      snap       <= '0;
      snap_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_CAPTURE) begin
        snap       <= timer_count;
        snap_valid <= 1'b1;
      end else if (sample_wr && !busy) begin
        snap_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      A_CTRL:    rd_mux[0]   = timer_en;
      A_WRAP_L:  rd_mux      = wrap_l;
      A_WRAP_H:  rd_mux      = wrap_h;
      A_COUNT_L: rd_mux      = snap[DATA_W-1:0];
      A_COUNT_H: rd_mux      = snap[2*DATA_W-1:DATA_W];
      A_STATUS:  rd_mux[1:0] = {snap_valid, busy};
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= accept;
      rdata <= accept ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_timer_csr.sv
// Bench for timer_csr: directed scenarios plus randomized register traffic against a register-map model,
// with a simple behavioural timer core driving timer_count.
module tb_timer_csr;
  localparam int DW = 32;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            valid = 1'b0;
  logic [AW-1:0]   address = '0;
  logic [DW-1:0]   wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic [DW-1:0]   rdata;
  logic            ready;
  logic            timer_en;
  logic [DW-1:0]   wrap_h;
  logic [DW-1:0]   wrap_l;
  logic            timer_s;
  logic [2*DW-1:0] timer_count;

  int n_checks = 0;
  int n_pass = 0;

  // Behavioural timer core: free counter, TIMER_COUNT latched on the sample strobe.
  logic [63:0] tm_cnt = 64'd0;
  logic [63:0] tm_latched = 64'd0;
  logic        force_on = 1'b0;
  logic [63:0] force_val = 64'd0;
  int          pulse_cnt = 0;

  // Expected architectural state.
  logic        exp_en = 1'b0;
  logic [31:0] exp_wl = '0;
  logic [31:0] exp_wh = '0;
  logic [63:0] exp_snap = '0;
  logic        exp_sv = 1'b0;

  timer_csr #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready), .timer_en(timer_en), .wrap_h(wrap_h), .wrap_l(wrap_l),
    .timer_s(timer_s), .timer_count(timer_count)
  );

  always #5 clk = ~clk;

  assign timer_count = force_on ? force_val : tm_latched;

  always @(posedge clk) begin
    if (timer_s) tm_latched <= tm_cnt;
    if (timer_en) tm_cnt <= (tm_cnt == {wrap_h, wrap_l}) ? 64'd0 : tm_cnt + 64'd1;
  end

  always @(negedge clk) if (timer_s === 1'b1) pulse_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Starts and ends at a negedge with valid low and ready low; one idle cycle after each completion.
  task automatic bus_xfer(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output int lat);
    valid = 1'b1; address = a; wdata = d; wstrb = s;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (ready !== 1'b1 && lat < 8);
    rd = rdata;
    valid = 1'b0; wstrb = '0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
    case (a)
      3'd0: return {31'd0, exp_en};
      3'd2: return exp_wl;
      3'd3: return exp_wh;
      3'd4: return exp_snap[31:0];
      3'd5: return exp_snap[63:32];
      3'd6: return {30'd0, exp_sv, 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  task automatic test_reset();
    logic [31:0] rd;
    int lat;
    rst = 1'b1;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    n_checks++; if (rdata !== 32'd0) $display("FAIL reset_rdata: got %h want 0", rdata); else n_pass++;
    n_checks++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready); else n_pass++;
    n_checks++; if (timer_en !== 1'b0) $display("FAIL reset_timer_en: got %b want 0", timer_en); else n_pass++;
    n_checks++; if (wrap_h !== 32'd0) $display("FAIL reset_wrap_h: got %h want 0", wrap_h); else n_pass++;
    n_checks++; if (wrap_l !== 32'd0) $display("FAIL reset_wrap_l: got %h want 0", wrap_l); else n_pass++;
    n_checks++; if (timer_s !== 1'b0) $display("FAIL reset_timer_s: got %b want 0", timer_s); else n_pass++;
    for (int a = 0; a < 8; a++) begin
      bus_xfer(3'(a), 32'd0, 4'h0, rd, lat);
      n_checks++; if (lat !== 1) $display("FAIL reset_read_lat[%0d]: got %0d want 1", a, lat); else n_pass++;
      n_checks++; if (rd !== 32'd0) $display("FAIL reset_read[%0d]: got %h want 0", a, rd); else n_pass++;
    end
  endtask

  task automatic test_config();
    logic [31:0] rd;
    int lat;
    bus_xfer(3'd2, 32'd150, 4'hF, rd, lat);
    n_checks++; if (lat !== 1) $display("FAIL cfg_lat: got %0d want 1", lat); else n_pass++;
    n_checks++; if (wrap_l !== 32'd150) $display("FAIL cfg_wrap_l: got %0d want 150", wrap_l); else n_pass++;
    bus_xfer(3'd3, 32'd0, 4'hF, rd, lat);
    n_checks++; if (wrap_h !== 32'd0) $display("FAIL cfg_wrap_h: got %h want 0", wrap_h); else n_pass++;
    bus_xfer(3'd0, 32'd1, 4'hF, rd, lat);
    n_checks++; if (timer_en !== 1'b1) $display("FAIL cfg_timer_en: got %b want 1", timer_en); else n_pass++;
    bus_xfer(3'd0, 32'd0, 4'h0, rd, lat);
    n_checks++; if (rd !== 32'd1) $display("FAIL cfg_ctrl_rb: got %h want 1", rd); else n_pass++;
    n_checks++; if (timer_en !== 1'b1) $display("FAIL cfg_strb0_no_write: got %b want 1", timer_en); else n_pass++;
    bus_xfer(3'd2, 32'd0, 4'h0, rd, lat);
    n_checks++; if (rd !== 32'd150) $display("FAIL cfg_wrap_l_rb: got %0d want 150", rd); else n_pass++;
    bus_xfer(3'd3, 32'd0, 4'h0, rd, lat);
    n_checks++; if (rd !== 32'd0) $display("FAIL cfg_wrap_h_rb: got %h want 0", rd); else n_pass++;
    bus_xfer(3'd2, 32'hAABBCCDD, 4'b0010, rd, lat);
    n_checks++; if (wrap_l !== 32'h0000CC96) $display("FAIL cfg_byte_strobe: got %h want 0000cc96", wrap_l); else n_pass++;
    bus_xfer(3'd2, 32'd150, 4'b0010, rd, lat);
    n_checks++; if (wrap_l !== 32'd150) $display("FAIL cfg_byte_restore: got %h want 96", wrap_l); else n_pass++;
    bus_xfer(3'd4, 32'hFFFFFFFF, 4'hF, rd, lat);
    bus_xfer(3'd4, 32'd0, 4'h0, rd, lat);
    n_checks++; if (rd !== 32'd0) $display("FAIL cfg_ro_ignored: got %h want 0", rd); else n_pass++;
    exp_en = 1'b1; exp_wl = 32'd150; exp_wh = 32'd0;
  endtask

  task automatic test_back_to_back();
    logic exp_rdy [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    valid = 1'b1; address = 3'd2; wstrb = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) valid = 1'b0;
      n_checks++; if (ready !== exp_rdy[i]) $display("FAIL b2b_ready[%0d]: got %b want %b", i, ready, exp_rdy[i]); else n_pass++;
      if (exp_rdy[i]) begin
        n_checks++; if (rdata !== exp_wl) $display("FAIL b2b_rdata[%0d]: got %h want %h", i, rdata, exp_wl); else n_pass++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_sample();
    logic [31:0] rd;
    logic [63:0] exp;
    int lat;
    int p0;
    repeat (100) @(negedge clk);
    p0 = pulse_cnt;
    n_checks++; if (timer_s !== 1'b0) $display("FAIL smp_pulse_before: got %b want 0", timer_s); else n_pass++;
    valid = 1'b1; address = 3'd1; wdata = 32'd1; wstrb = 4'hF;
    @(negedge clk);
    n_checks++; if (ready !== 1'b1) $display("FAIL smp_ready: got %b want 1", ready); else n_pass++;
    n_checks++; if (timer_s !== 1'b1) $display("FAIL smp_pulse_n1: got %b want 1", timer_s); else n_pass++;
    exp = tm_cnt;
    address = 3'd6; wstrb = 4'h0;
    @(negedge clk);
    n_checks++; if (timer_s !== 1'b0) $display("FAIL smp_pulse_n2: got %b want 0", timer_s); else n_pass++;
    @(negedge clk);
    n_checks++; if (rdata !== 32'd1 || ready !== 1'b1) $display("FAIL smp_status_busy: got %h rdy %b want 1", rdata, ready); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    valid = 1'b0;
    n_checks++; if (rdata !== 32'd2 || ready !== 1'b1) $display("FAIL smp_status_done: got %h rdy %b want 2", rdata, ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (pulse_cnt - p0 !== 1) $display("FAIL smp_pulse_count: got %0d want 1", pulse_cnt - p0); else n_pass++;
    bus_xfer(3'd4, 32'd0, 4'h0, rd, lat);
    n_checks++; if (rd !== exp[31:0]) $display("FAIL smp_count_l: got %h want %h", rd, exp[31:0]); else n_pass++;
    bus_xfer(3'd5, 32'd0, 4'h0, rd, lat);
    n_checks++; if (rd !== 32'd0) $display("FAIL smp_count_h: got %h want 0", rd); else n_pass++;
    bus_xfer(3'd1, 32'd0, 4'h0, rd, lat);
    n_checks++; if (rd !== 32'd0) $display("FAIL smp_sample_reads0: got %h want 0", rd); else n_pass++;
    exp_snap = exp; exp_sv = 1'b1;
  endtask

  task automatic test_retrigger();
    logic [31:0] rd;
    logic [63:0] exp;
    int lat;
    int p0;
    p0 = pulse_cnt;
    valid = 1'b1; address = 3'd1; wdata = 32'd1; wstrb = 4'hF;
    @(negedge clk);
    exp = tm_cnt;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (ready !== 1'b1) $display("FAIL retrig_second_ready: got %b want 1", ready); else n_pass++;
    valid = 1'b0; wstrb = 4'h0;
    repeat (6) @(negedge clk);
    n_checks++; if (pulse_cnt - p0 !== 1) $display("FAIL retrig_pulses: got %0d want 1", pulse_cnt - p0); else n_pass++;
    bus_xfer(3'd6, 32'd0, 4'h0, rd, lat);
    n_checks++; if (rd !== 32'd2) $display("FAIL retrig_status: got %h want 2", rd); else n_pass++;
    bus_xfer(3'd4, 32'd0, 4'h0, rd, lat);
    n_checks++; if (rd !== exp[31:0]) $display("FAIL retrig_count_l: got %h want %h", rd, exp[31:0]); else n_pass++;
    bus_xfer(3'd5, 32'd0, 4'h0, rd, lat);
    n_checks++; if (rd !== exp[63:32]) $display("FAIL retrig_count_h: got %h want %h", rd, exp[63:32]); else n_pass++;
    exp_snap = exp;
  endtask

  task automatic test_coherence();
    logic [31:0] rd;
    int lat;
    bit done;
    force_on = 1'b1;
    force_val = 64'h0000_0000_FFFF_FFFF;
    bus_xfer(3'd1, 32'd1, 4'hF, rd, lat);
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      bus_xfer(3'd6, 32'd0, 4'h0, rd, lat);
      if (rd == 32'd2) done = 1'b1;
    end
    n_checks++; if (done !== 1'b1) $display("FAIL coh_capture_seen: got status %h want 2", rd); else n_pass++;
    force_val = 64'h0000_0001_0000_0000;
    bus_xfer(3'd4, 32'd0, 4'h0, rd, lat);
    n_checks++; if (rd !== 32'hFFFFFFFF) $display("FAIL coh_count_l: got %h want ffffffff", rd); else n_pass++;
    bus_xfer(3'd5, 32'd0, 4'h0, rd, lat);
    n_checks++; if (rd !== 32'd0) $display("FAIL coh_count_h: got %h want 0", rd); else n_pass++;
    force_on = 1'b0;
    exp_snap = 64'h0000_0000_FFFF_FFFF; exp_sv = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] rd, d, er;
    logic [AW-1:0] a;
    logic [3:0] s;
    int lat;
    for (int i = 0; i < 60; i++) begin
      a = AW'($urandom_range(0, 7));
      d = $urandom;
      s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
      if (a == 3'd1) s = 4'h0;
      er = model_read(a);
      bus_xfer(a, d, s, rd, lat);
      if (s != 4'h0) begin
        if (a == 3'd0 && s[0]) exp_en = d[0];
        for (int b = 0; b < 4; b++) begin
          if (s[b] && a == 3'd2) exp_wl[b*8 +: 8] = d[b*8 +: 8];
          if (s[b] && a == 3'd3) exp_wh[b*8 +: 8] = d[b*8 +: 8];
        end
      end else begin
        n_checks++; if (rd !== er) $display("FAIL rnd_read[%0d] a=%0d: got %h want %h", i, a, rd, er); else n_pass++;
      end
      n_checks++; if (lat !== 1) $display("FAIL rnd_lat[%0d]: got %0d want 1", i, lat); else n_pass++;
      n_checks++; if ({timer_en, wrap_h, wrap_l} !== {exp_en, exp_wh, exp_wl})
        $display("FAIL rnd_regs[%0d]: got %b/%h/%h want %b/%h/%h", i, timer_en, wrap_h, wrap_l, exp_en, exp_wh, exp_wl);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_sample();
    logic [31:0] rd;
    int lat;
    int p0;
    p0 = pulse_cnt;
    valid = 1'b1; address = 3'd1; wdata = 32'd1; wstrb = 4'hF;
    @(negedge clk);
    n_checks++; if (timer_s !== 1'b1) $display("FAIL rms_pulse: got %b want 1", timer_s); else n_pass++;
    valid = 1'b0; wstrb = 4'h0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (timer_s !== 1'b0) $display("FAIL rms_timer_s: got %b want 0", timer_s); else n_pass++;
    n_checks++; if (ready !== 1'b0) $display("FAIL rms_ready: got %b want 0", ready); else n_pass++;
    n_checks++; if ({timer_en, wrap_h, wrap_l} !== 65'd0) $display("FAIL rms_cfg: got %b/%h/%h want 0", timer_en, wrap_h, wrap_l); else n_pass++;
    bus_xfer(3'd6, 32'd0, 4'h0, rd, lat);
    n_checks++; if (rd !== 32'd0) $display("FAIL rms_status: got %h want 0", rd); else n_pass++;
    bus_xfer(3'd4, 32'd0, 4'h0, rd, lat);
    n_checks++; if (rd !== 32'd0) $display("FAIL rms_count_l: got %h want 0", rd); else n_pass++;
    bus_xfer(3'd5, 32'd0, 4'h0, rd, lat);
    n_checks++; if (rd !== 32'd0) $display("FAIL rms_count_h: got %h want 0", rd); else n_pass++;
    n_checks++; if (pulse_cnt - p0 !== 1) $display("FAIL rms_pulses: got %0d want 1", pulse_cnt - p0); else n_pass++;
    bus_xfer(3'd2, 32'h0000_1234, 4'hF, rd, lat);
    n_checks++; if (lat !== 1) $display("FAIL rms_next_lat: got %0d want 1", lat); else n_pass++;
    bus_xfer(3'd2, 32'd0, 4'h0, rd, lat);
    n_checks++; if (rd !== 32'h0000_1234) $display("FAIL rms_next_rb: got %h want 00001234", rd); else n_pass++;
    exp_en = 1'b0; exp_wh = '0; exp_wl = 32'h0000_1234; exp_snap = '0; exp_sv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_config();
    test_back_to_back();
    test_sample();
    test_retrigger();
    test_coherence();
    test_random();
    test_reset_mid_sample();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
